// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encodings, FIFO sizing and the NI packetizer state type.
// Also intended for reuse by the switch controller and the ni_depacketizer.
package noc_pkg;

    localparam int FLIT_W   = 8;
    localparam int NODE_W   = 2;
    localparam int FIFO_AW  = 3;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    localparam logic [5:0]        HEAD_TAG  = 6'b101111;
    localparam logic [FLIT_W-1:0] TRAILER   = 8'hFF;
    localparam logic [FLIT_W-1:0] IDLE_FLIT = 8'h00;
    localparam logic [FLIT_W-1:0] SUB_BYTE  = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_FREE,
        ST_HEAD,
        ST_BODY,
        ST_TRAILER,
        ST_GAP
    } ni_state_t;

    function automatic logic [FLIT_W-1:0] head_flit(input logic [NODE_W-1:0] node);
        return {HEAD_TAG, node};
    endfunction

    // Payload bytes that would collide with the idle or trailer codes on the link.
    function automatic logic reserved_byte(input logic [FLIT_W-1:0] b);
        return (b == IDLE_FLIT) || (b == TRAILER);
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// 8-entry payload FIFO with first-word fall-through read data.
// Guards its own pointers: pushes when full and pops when empty are dropped.
module ni_fifo
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] wdata,
    input  logic              pop,
    output logic [FLIT_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  count
);

    logic [FLIT_W-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: buffers a core payload, waits for an injection grant,
// then emits head, body and trailer flits back to back followed by one idle gap cycle.
module ni_packetizer
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NODE_W-1:0] dest,
    input  logic [2:0]        len,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              free,
    output logic              start_ready,
    output logic              data_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              busy,
    output logic              pkt_sent,
    output logic              err_illegal
);

    ni_state_t         state;
    logic [NODE_W-1:0] dest_q;
    logic [3:0]        len_q;
    logic [3:0]        sent_cnt;

    logic              push;
    logic              pop;
    logic              bad_byte;
    logic [FLIT_W-1:0] fifo_wdata;
    logic [FLIT_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;

    assign bad_byte   = reserved_byte(data_in);
    assign fifo_wdata = bad_byte ? SUB_BYTE : data_in;
    assign push       = (state == ST_LOAD) && data_valid && data_ready && !fifo_full;
    // The FIFO is read while the flit register loads the next body byte.
    assign pop        = ((state == ST_HEAD) || ((state == ST_BODY) && (sent_cnt != len_q)))
                        && !fifo_empty;

    ni_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // flit_out is loaded on the same edge that enters a state, so it always
    // shows the flit belonging to the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            sent_cnt    <= '0;
            flit_out    <= IDLE_FLIT;
            start_ready <= 1'b0;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            pkt_sent    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            pkt_sent <= 1'b0;
            if (push && bad_byte) err_illegal <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_ready && start) begin
                        dest_q      <= dest;
                        len_q       <= (len == 3'd0) ? 4'd8 : {1'b0, len};
                        state       <= ST_LOAD;
                        start_ready <= 1'b0;
                        data_ready  <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        start_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (push && ((fifo_count + 4'd1) == len_q)) begin
                        state      <= ST_WAIT_FREE;
                        data_ready <= 1'b0;
                    end
                end
                ST_WAIT_FREE: begin
                    if (free) begin
                        state    <= ST_HEAD;
                        flit_out <= head_flit(dest_q);
                    end
                end
                ST_HEAD: begin
                    state    <= ST_BODY;
                    flit_out <= fifo_rdata;
                    sent_cnt <= 4'd1;
                end
                ST_BODY: begin
                    if (sent_cnt == len_q) begin
                        state    <= ST_TRAILER;
                        flit_out <= TRAILER;
                    end else begin
                        flit_out <= fifo_rdata;
                        sent_cnt <= sent_cnt + 4'd1;
                    end
                end
                ST_TRAILER: begin
                    state    <= ST_GAP;
                    flit_out <= IDLE_FLIT;
                    pkt_sent <= 1'b1;
                end
                ST_GAP: begin
                    state       <= ST_IDLE;
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    flit_out <= IDLE_FLIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: directed scenarios plus randomized packets
// compared against a flit-list reference model.
module tb_ni_packetizer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [2:0] len = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       free = 1'b0;
    logic       start_ready;
    logic       data_ready;
    logic [7:0] flit_out;
    logic       busy;
    logic       pkt_sent;
    logic       err_illegal;

    ni_packetizer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dest        (dest),
        .len         (len),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .free        (free),
        .start_ready (start_ready),
        .data_ready  (data_ready),
        .flit_out    (flit_out),
        .busy        (busy),
        .pkt_sent    (pkt_sent),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int timeouts = 0;

    logic [7:0] payload [8];
    logic [7:0] exp_flits [$];
    logic [7:0] obs_flits [$];
    logic [7:0] obs_wait [$];
    bit         obs_sent [$];
    bit         obs_sr [$];
    bit         obs_dr [$];
    bit         sr_after;
    bit         busy_after;

    // Reference: a packet is head, sanitized payload in order, trailer, then one idle gap.
    function automatic void build_expected(input logic [1:0] d, input logic [2:0] l);
        int n;
        n = (l == 3'd0) ? 8 : int'(l);
        exp_flits.delete();
        exp_flits.push_back({6'b101111, d});
        for (int i = 0; i < n; i++)
            exp_flits.push_back((payload[i] == 8'h00 || payload[i] == 8'hFF) ? 8'hFE : payload[i]);
        exp_flits.push_back(8'hFF);
        exp_flits.push_back(8'h00);
    endfunction

    // Drives one packet and records what the DUT emits; ncap>0 stops capture early.
    task automatic drive_packet(input logic [1:0] d, input logic [2:0] l, input int free_delay,
                                input bit disturb, input int ncap);
        int n;
        int acc;
        int guard;
        int ncyc;
        n = (l == 3'd0) ? 8 : int'(l);
        acc = 0;
        obs_flits.delete(); obs_sent.delete(); obs_sr.delete(); obs_dr.delete(); obs_wait.delete();
        guard = 0;
        while (start_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (start_ready !== 1'b1) timeouts++;
        start = 1'b1; dest = d; len = l;
        @(negedge clk);
        start = 1'b0; dest = 2'($urandom); len = 3'($urandom);
        guard = 0;
        while (acc < n && guard < 200) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data_in = payload[acc];
            if (data_valid && data_ready) acc++;
            @(negedge clk);
            guard++;
        end
        if (acc < n) timeouts++;
        for (int i = 0; i < free_delay; i++) begin
            obs_wait.push_back(flit_out);
            free = 1'b0;
            data_valid = 1'($urandom);
            data_in = 8'h5A;
            @(negedge clk);
        end
        data_valid = 1'b0;
        free = 1'b1;
        ncyc = (ncap > 0 && ncap < n + 3) ? ncap : n + 3;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            obs_flits.push_back(flit_out);
            obs_sent.push_back(pkt_sent);
            obs_sr.push_back(start_ready);
            obs_dr.push_back(data_ready);
            free = disturb ? 1'($urandom) : 1'b0;
            start = disturb && (k == 1);
            if (disturb) begin
                dest = 2'($urandom);
                len = 3'($urandom);
            end
        end
        start = 1'b0;
        free = 1'b0;
        if (ncyc == n + 3) begin
            @(negedge clk);
            sr_after = start_ready;
            busy_after = busy;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({flit_out, busy, pkt_sent, err_illegal, data_ready, start_ready} !== 13'd0)
            $display("FAIL reset_outputs: got flit=%02h busy=%b sent=%b err=%b dr=%b sr=%b required all 0",
                     flit_out, busy, pkt_sent, err_illegal, data_ready, start_ready);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b required 1", start_ready);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || flit_out !== 8'h00) $display("FAIL reset_idle: got busy=%b flit=%02h required 0/00", busy, flit_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        build_expected(2'd2, 3'd3);
        drive_packet(2'd2, 3'd3, 0, 1'b0, 0);
        for (int i = 0; i < exp_flits.size(); i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL basic_flit[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
            n_checks++;
            if (obs_sent[i] !== (i == exp_flits.size() - 1)) $display("FAIL basic_pkt_sent[%0d]: got %b required %b", i, obs_sent[i], (i == exp_flits.size() - 1));
            else n_pass++;
            n_checks++;
            if (obs_sr[i] !== 1'b0 || obs_dr[i] !== 1'b0) $display("FAIL basic_ready[%0d]: got sr=%b dr=%b required 0/0", i, obs_sr[i], obs_dr[i]);
            else n_pass++;
        end
        n_checks++;
        if (sr_after !== 1'b1 || busy_after !== 1'b0) $display("FAIL basic_after: got sr=%b busy=%b required 1/0", sr_after, busy_after);
        else n_pass++;
        n_checks++;
        if (err_illegal !== 1'b0 || timeouts != 0) $display("FAIL basic_err: got err=%b timeouts=%0d required 0/0", err_illegal, timeouts);
        else n_pass++;
    endtask

    task automatic test_long_wait();
        for (int i = 0; i < 8; i++) payload[i] = 8'(i + 1);
        build_expected(2'd0, 3'd0);
        drive_packet(2'd0, 3'd0, 5, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs_wait[i] !== 8'h00) $display("FAIL wait_idle[%0d]: got %02h required 00", i, obs_wait[i]);
            else n_pass++;
        end
        for (int i = 0; i < exp_flits.size(); i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL len8_flit[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_sent[exp_flits.size() - 1] !== 1'b1 || timeouts != 0)
            $display("FAIL len8_pkt_sent: got %b timeouts=%0d required 1/0", obs_sent[exp_flits.size() - 1], timeouts);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [1:0] d;
        d = 2'($urandom);
        payload[0] = 8'h00; payload[1] = 8'hFF;
        n_checks++;
        if (err_illegal !== 1'b0) $display("FAIL illegal_pre: got %b required 0", err_illegal);
        else n_pass++;
        build_expected(d, 3'd2);
        drive_packet(d, 3'd2, 1, 1'b0, 0);
        for (int i = 0; i < exp_flits.size(); i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL illegal_flit[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
        end
        n_checks++;
        if (err_illegal !== 1'b1) $display("FAIL illegal_sticky: got %b required 1", err_illegal);
        else n_pass++;
    endtask

    task automatic test_disturb();
        for (int i = 0; i < 8; i++) payload[i] = 8'($urandom_range(1, 254));
        build_expected(2'd1, 3'd5);
        drive_packet(2'd1, 3'd5, 0, 1'b1, 0);
        for (int i = 0; i < exp_flits.size(); i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL disturb_flit[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
            n_checks++;
            if (obs_sr[i] !== 1'b0) $display("FAIL disturb_start_ready[%0d]: got %b required 0", i, obs_sr[i]);
            else n_pass++;
        end
        n_checks++;
        if (sr_after !== 1'b1) $display("FAIL disturb_sr_after: got %b required 1", sr_after);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || flit_out !== 8'h00) $display("FAIL disturb_not_queued[%0d]: got busy=%b flit=%02h required 0/00", i, busy, flit_out);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0] d;
        logic [2:0] l;
        int errs;
        for (int p = 0; p < 20; p++) begin
            d = 2'($urandom);
            l = 3'($urandom);
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 9))
                    0: payload[i] = 8'h00;
                    1: payload[i] = 8'hFF;
                    default: payload[i] = 8'($urandom);
                endcase
            end
            build_expected(d, l);
            drive_packet(d, l, $urandom_range(0, 4), 1'($urandom), 0);
            for (int i = 0; i < exp_flits.size(); i++) begin
                n_checks++;
                if (obs_flits[i] !== exp_flits[i])
                    $display("FAIL rand_pkt%0d_flit[%0d]: got %02h required %02h", p, i, obs_flits[i], exp_flits[i]);
                else n_pass++;
            end
            errs = 0;
            for (int i = 0; i < exp_flits.size(); i++)
                if (obs_sent[i] !== (i == exp_flits.size() - 1)) errs++;
            n_checks++;
            if (errs != 0) $display("FAIL rand_pkt%0d_pkt_sent: got %0d wrong cycles required 0", p, errs);
            else n_pass++;
        end
        n_checks++;
        if (err_illegal !== 1'b1 || timeouts != 0) $display("FAIL rand_end: got err=%b timeouts=%0d required 1/0", err_illegal, timeouts);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) payload[i] = 8'($urandom_range(1, 254));
        build_expected(2'd3, 3'd4);
        drive_packet(2'd3, 3'd4, 0, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL abort_prefix[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
        end
        data_valid = 1'b0;
        free = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({flit_out, busy, pkt_sent, err_illegal, data_ready, start_ready} !== 13'd0)
            $display("FAIL abort_immediate: got flit=%02h busy=%b sent=%b err=%b dr=%b sr=%b required all 0",
                     flit_out, busy, pkt_sent, err_illegal, data_ready, start_ready);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (flit_out !== 8'h00 || pkt_sent !== 1'b0) $display("FAIL abort_no_trailer[%0d]: got flit=%02h sent=%b required 00/0", i, flit_out, pkt_sent);
            else n_pass++;
        end
        payload[0] = 8'h77;
        build_expected(2'd1, 3'd1);
        drive_packet(2'd1, 3'd1, 2, 1'b0, 0);
        for (int i = 0; i < exp_flits.size(); i++) begin
            n_checks++;
            if (obs_flits[i] !== exp_flits[i]) $display("FAIL after_abort_flit[%0d]: got %02h required %02h", i, obs_flits[i], exp_flits[i]);
            else n_pass++;
        end
        n_checks++;
        if (sr_after !== 1'b1 || err_illegal !== 1'b0 || timeouts != 0)
            $display("FAIL after_abort_state: got sr=%b err=%b timeouts=%0d required 1/0/0", sr_after, err_illegal, timeouts);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_wait();
        test_illegal();
        test_disturb();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
